// File: rtl/pit_8253.sv
// pit_8253: 8253-style programmable interval timer, three channels on I/O
// ports BASE..BASE+3. A phase accumulator derives the PIT tick from iClk.
// Counting is binary only, in mode 0 (one-shot), mode 2 (rate generator)
// and mode 3 (square wave).
// Optional build macro PIT_LATCH_EN adds the counter-latch command (RW = 00).
module pit_8253 #(
    parameter int unsigned CLK_HZ = 10000000,
    parameter int unsigned PIT_HZ = 1193182,
    parameter logic [15:0] BASE   = 16'h0040
) (
    input  logic        iClk,
    input  logic        iResetN,
    input  logic [15:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iIoWr,
    input  logic        iIoRd,
    input  logic        iGate2,
    output logic        oSel,
    output logic [7:0]  oData,
    output logic        oOut0,
    output logic        oOut1,
    output logic        oOut2
);
    localparam int ACC_W = $clog2(2 * CLK_HZ);

    // Only three behaviours exist; modes 1/4/5 fold into mode 0, 6/7 into 2/3.
    typedef enum logic [1:0] {
        M_INT    = 2'd0,
        M_RATE   = 2'd2,
        M_SQUARE = 2'd3
    } mode_e;

    function automatic mode_e decode_mode(input logic [1:0] m_low);
        case (m_low)
            2'b10:   return M_RATE;
            2'b11:   return M_SQUARE;
            default: return M_INT;
        endcase
    endfunction

    // ---------------- tick generator ----------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             tick;

    // Phase accumulator: add PIT_HZ each clock, wrap at CLK_HZ and emit a tick.
    always_comb begin
        acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(PIT_HZ);
        tick    = (acc_sum >= (ACC_W + 1)'(CLK_HZ));
        acc_d   = tick ? ACC_W'(acc_sum - (ACC_W + 1)'(CLK_HZ)) : acc_sum[ACC_W-1:0];
    end

    // Accumulator register.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) acc_q <= '0;
        else          acc_q <= acc_d;
    end

    // ---------------- bus decode ----------------
    logic       in_range;
    logic [1:0] port;
    logic       wr_hit;
    logic       rd_hit;
    logic       cw_wr;

    assign in_range = ({1'b0, iAddr} >= {1'b0, BASE}) &&
                      ({1'b0, iAddr} <= ({1'b0, BASE} + 17'd3));
    assign port     = 2'(iAddr - BASE);
    assign wr_hit   = iIoWr && in_range;
    assign rd_hit   = iIoRd && in_range;
    assign cw_wr    = wr_hit && (port == 2'd3);
    assign oSel     = rd_hit;

    wire [2:0][7:0] rd_byte;
    wire [2:0]      out_vec;

    // ---------------- channels ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [15:0] count_q, count_d;
        logic [15:0] reload_q, reload_d;
        logic [15:0] latch_q, latch_d;
        mode_e       mode_q, mode_d;
        logic [1:0]  rw_q, rw_d;
        logic [7:0]  lsb_q, lsb_d;
        logic        wr_tog_q, wr_tog_d;
        logic        rd_tog_q, rd_tog_d;
        logic        null_q, null_d;
        logic        pend_q, pend_d;
        logic        out_q, out_d;
        logic        gate_q, gate_d;
        logic        grl_q, grl_d;
        logic        extra_q, extra_d;
        logic        held_q, held_d;

        logic        gate;
        logic        cw_sel;
        logic        cnt_wr;
        logic        rd_sel;
        logic        wr_any;
        logic        complete;
        logic [15:0] new_val;
        logic [15:0] view;
        logic [15:0] load_val;
        logic [15:0] dec1;
        logic [15:0] dec2;
        logic [7:0]  rd_b;

        assign gate     = (gi == 2) ? iGate2 : 1'b1;
        assign cw_sel   = cw_wr && (iData[7:6] == 2'(gi));
        assign cnt_wr   = wr_hit && (port == 2'(gi));
        assign rd_sel   = rd_hit && (port == 2'(gi));
        // A null channel shows its reload value; a held latch overrides both.
        assign view     = held_q ? latch_q : (null_q ? reload_q : count_q);
        // Square wave counts by two from the even part of N.
        assign load_val = (mode_q == M_SQUARE) ? {reload_q[15:1], 1'b0} : reload_q;
        assign dec1     = count_q - 16'd1;
        assign dec2     = count_q - 16'd2;

        // Read byte selection following the RW access mode and read toggle.
        always_comb begin
            case (rw_q)
                2'b10:   rd_b = view[15:8];
                2'b11:   rd_b = rd_tog_q ? view[15:8] : view[7:0];
                default: rd_b = view[7:0];
            endcase
        end
        assign rd_byte[gi] = rd_b;
        assign out_vec[gi] = out_q;

        // Channel next state: bus reads/writes first, then tick-driven counting.
        always_comb begin
            count_d  = count_q;
            reload_d = reload_q;
            latch_d  = latch_q;
            mode_d   = mode_q;
            rw_d     = rw_q;
            lsb_d    = lsb_q;
            wr_tog_d = wr_tog_q;
            rd_tog_d = rd_tog_q;
            null_d   = null_q;
            pend_d   = pend_q;
            out_d    = out_q;
            gate_d   = gate;
            grl_d    = grl_q | (gate & ~gate_q);
            extra_d  = extra_q;
            held_d   = held_q;
            wr_any   = 1'b0;
            complete = 1'b0;
            new_val  = reload_q;

            if (rd_sel) begin
                if (rw_q == 2'b11) rd_tog_d = ~rd_tog_q;
                // The latch is released by its last byte.
                if (held_q && ((rw_q != 2'b11) || rd_tog_q)) held_d = 1'b0;
            end

            if (cw_sel && (iData[5:4] != 2'b00)) begin
                wr_any   = 1'b1;
                mode_d   = decode_mode(iData[2:1]);
                rw_d     = iData[5:4];
                wr_tog_d = 1'b0;
                rd_tog_d = 1'b0;
                null_d   = 1'b1;
                pend_d   = 1'b0;
                grl_d    = 1'b0;
                extra_d  = 1'b0;
                held_d   = 1'b0;
                out_d    = (decode_mode(iData[2:1]) != M_INT);
            end
`ifdef PIT_LATCH_EN
            else if (cw_sel) begin
                wr_any = 1'b1;
                if (!held_q) begin
                    latch_d = view;
                    held_d  = 1'b1;
                end
            end
`endif

            if (cnt_wr && (rw_q != 2'b00)) begin
                wr_any = 1'b1;
                case (rw_q)
                    2'b01: begin
                        new_val  = {8'h00, iData};
                        complete = 1'b1;
                    end
                    2'b10: begin
                        new_val  = {iData, 8'h00};
                        complete = 1'b1;
                    end
                    default: begin
                        if (!wr_tog_q) begin
                            lsb_d    = iData;
                            wr_tog_d = 1'b1;
                        end else begin
                            new_val  = {iData, lsb_q};
                            wr_tog_d = 1'b0;
                            complete = 1'b1;
                        end
                    end
                endcase
                if (complete) begin
                    reload_d = new_val;
                    // Mode 0 restarts at once; running modes 2/3 pick it up at terminal count.
                    if (mode_q == M_INT) begin
                        out_d  = 1'b0;
                        null_d = 1'b1;
                        pend_d = 1'b1;
                    end else if (null_q) begin
                        pend_d = 1'b1;
                    end
                end
            end

            if (tick && !wr_any && gate) begin
                if (pend_q || (grl_q && !null_q)) begin
                    count_d = load_val;
                    null_d  = 1'b0;
                    pend_d  = 1'b0;
                    grl_d   = 1'b0;
                    extra_d = 1'b0;
                    out_d   = (mode_q != M_INT);
                end else if (null_q) begin
                    grl_d = 1'b0;
                end else begin
                    case (mode_q)
                        M_RATE: begin
                            if (count_q == 16'd2) begin
                                count_d = dec1;
                                out_d   = 1'b0;
                            end else if (count_q == 16'd1) begin
                                count_d = reload_q;
                                out_d   = 1'b1;
                            end else begin
                                count_d = dec1;
                            end
                        end
                        M_SQUARE: begin
                            // Odd N: the high phase holds at zero for one extra tick.
                            if (extra_q) begin
                                extra_d = 1'b0;
                                out_d   = ~out_q;
                                count_d = load_val;
                            end else if (dec2 == 16'd0) begin
                                if (out_q && reload_q[0]) begin
                                    extra_d = 1'b1;
                                    count_d = 16'd0;
                                end else begin
                                    out_d   = ~out_q;
                                    count_d = load_val;
                                end
                            end else begin
                                count_d = dec2;
                            end
                        end
                        default: begin
                            count_d = dec1;
                            if (dec1 == 16'd0) out_d = 1'b1;
                        end
                    endcase
                end
            end

            if (!gate && (mode_d != M_INT)) out_d = 1'b1;
        end

        // Channel state registers.
        always_ff @(posedge iClk or negedge iResetN) begin
            if (!iResetN) begin
                count_q  <= '0;
                reload_q <= '0;
                latch_q  <= '0;
                mode_q   <= M_INT;
                rw_q     <= 2'b00;
                lsb_q    <= '0;
                wr_tog_q <= 1'b0;
                rd_tog_q <= 1'b0;
                null_q   <= 1'b1;
                pend_q   <= 1'b0;
                out_q    <= 1'b0;
                gate_q   <= 1'b0;
                grl_q    <= 1'b0;
                extra_q  <= 1'b0;
                held_q   <= 1'b0;
            end else begin
                count_q  <= count_d;
                reload_q <= reload_d;
                latch_q  <= latch_d;
                mode_q   <= mode_d;
                rw_q     <= rw_d;
                lsb_q    <= lsb_d;
                wr_tog_q <= wr_tog_d;
                rd_tog_q <= rd_tog_d;
                null_q   <= null_d;
                pend_q   <= pend_d;
                out_q    <= out_d;
                gate_q   <= gate_d;
                grl_q    <= grl_d;
                extra_q  <= extra_d;
                held_q   <= held_d;
            end
        end
    end

    // Read data mux; the control port reads as all ones.
    always_comb begin
        case (port)
            2'd0:    oData = rd_byte[0];
            2'd1:    oData = rd_byte[1];
            2'd2:    oData = rd_byte[2];
            default: oData = 8'hFF;
        endcase
    end

    assign oOut0 = out_vec[0];
    assign oOut1 = out_vec[1];
    assign oOut2 = out_vec[2];
endmodule

// File: tb/tb_pit_8253.sv
// tb_pit_8253: directed scoreboard bench for pit_8253 (tick every 4 clocks).
module tb_pit_8253;
    logic        iClk = 1'b0;
    logic        iResetN = 1'b0;
    logic [15:0] iAddr = 16'h0000;
    logic [7:0]  iData = 8'h00;
    logic        iIoWr = 1'b0;
    logic        iIoRd = 1'b0;
    logic        iGate2 = 1'b1;
    logic        oSel;
    logic [7:0]  oData;
    logic        oOut0, oOut1, oOut2;

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt = 0;
    int acc_m = 0;
    logic [7:0] exp_q[$];

    pit_8253 #(.CLK_HZ(4), .PIT_HZ(1), .BASE(16'h0040)) dut (
        .iClk(iClk), .iResetN(iResetN), .iAddr(iAddr), .iData(iData),
        .iIoWr(iIoWr), .iIoRd(iIoRd), .iGate2(iGate2), .oSel(oSel),
        .oData(oData), .oOut0(oOut0), .oOut1(oOut1), .oOut2(oOut2)
    );

    always #5 iClk = ~iClk;

    // Reference tick generator: acc += 1, wrap at 4.
    always @(posedge iClk or negedge iResetN) begin
        if (!iResetN) acc_m <= 0;
        else if (acc_m + 1 >= 4) begin
            acc_m    <= acc_m + 1 - 4;
            tick_cnt <= tick_cnt + 1;
        end else acc_m <= acc_m + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            $display("chk %s observed=%h expected=%h", tag, obs, e);
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic wait_tick(input int target);
        int n = 0;
        while (tick_cnt < target && n < 5000) begin
            @(negedge iClk);
            n++;
        end
        if (tick_cnt < target) begin
            n_cmp++;
            n_err++;
            $error("FAIL tick_wait observed=%0d expected=%0d", tick_cnt, target);
        end
    endtask

    task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
        iAddr = a; iData = d; iIoWr = 1'b1;
        @(negedge iClk);
        iIoWr = 1'b0;
    endtask

    task automatic io_rd(input logic [15:0] a, output logic [7:0] d, output logic s);
        iAddr = a; iIoRd = 1'b1;
        #1;
        d = oData; s = oSel;
        @(negedge iClk);
        iIoRd = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic s;
        int base;

        // ---- reset state ----
        repeat (3) @(negedge iClk);
        push(8'd0); check("out0_rst", {7'd0, oOut0});
        push(8'd0); check("out1_rst", {7'd0, oOut1});
        push(8'd0); check("out2_rst", {7'd0, oOut2});
        iResetN = 1'b1;
        @(negedge iClk);
        push(8'h00); push(8'd1);
        io_rd(16'h0040, d, s);
        check("rd40_rst", d); check("sel40", {7'd0, s});

        // ---- decode ----
        push(8'd0); io_rd(16'h0044, d, s); check("sel44", {7'd0, s});
        push(8'd0); io_rd(16'h003F, d, s); check("sel3F", {7'd0, s});
        push(8'd1); push(8'hFF);
        io_rd(16'h0043, d, s);
        check("sel43", {7'd0, s}); check("rd43", d);

        // ---- mode 2 on channel 0, N = 4 ----
        io_wr(16'h0043, 8'h34);
        push(8'd1); check("out0_cw", {7'd0, oOut0});
        io_wr(16'h0040, 8'h04);
        io_wr(16'h0040, 8'h00);
        base = tick_cnt;
        for (int k = 0; k < 40; k++) begin
            push((k % 4 == 3) ? 8'd0 : 8'd1);
            wait_tick(base + 1 + k);
            check("out0_m2", {7'd0, oOut0});
        end
        // SC = 11 control word must not disturb any channel.
        io_wr(16'h0043, 8'hD6);
        for (int k = 40; k < 48; k++) begin
            push((k % 4 == 3) ? 8'd0 : 8'd1);
            wait_tick(base + 1 + k);
            check("out0_sc3", {7'd0, oOut0});
        end
        push(8'd0); check("out1_sc3", {7'd0, oOut1});
        push(8'd0); check("out2_sc3", {7'd0, oOut2});

        // ---- mode 3 on channel 2, N = 5 ----
        io_wr(16'h0043, 8'hB6);
        push(8'd1); check("out2_cw", {7'd0, oOut2});
        io_wr(16'h0042, 8'h05);
        io_wr(16'h0042, 8'h00);
        base = tick_cnt;
        for (int k = 0; k < 15; k++) begin
            push((k % 5 < 3) ? 8'd1 : 8'd0);
            wait_tick(base + 1 + k);
            check("out2_m3", {7'd0, oOut2});
        end
        iGate2 = 1'b0;
        @(negedge iClk);
        push(8'd1); check("out2_gate_lo", {7'd0, oOut2});
        push(8'h02); io_rd(16'h0042, d, s); check("cnt2_lsb_a", d);
        push(8'h00); io_rd(16'h0042, d, s); check("cnt2_msb_a", d);
        base = tick_cnt;
        wait_tick(base + 3);
        push(8'h02); io_rd(16'h0042, d, s); check("cnt2_lsb_frz", d);
        push(8'h00); io_rd(16'h0042, d, s); check("cnt2_msb_frz", d);
        push(8'd1); check("out2_frz", {7'd0, oOut2});
        base = tick_cnt;
        wait_tick(base + 1);
        iGate2 = 1'b1;
        base = tick_cnt;
        wait_tick(base + 1);
        push(8'h04); io_rd(16'h0042, d, s); check("cnt2_regate", d);
        push(8'h00); io_rd(16'h0042, d, s); check("cnt2_regate_msb", d);

        // ---- mode 0 on channel 1, LSB only, N = 3 ----
        io_wr(16'h0043, 8'h50);
        push(8'd0); check("out1_cw", {7'd0, oOut1});
        io_wr(16'h0041, 8'h03);
        base = tick_cnt;
        push(8'd0); check("out1_wr", {7'd0, oOut1});
        push(8'h03); io_rd(16'h0041, d, s); check("cnt1_null", d);
        for (int k = 0; k < 9; k++) begin
            push((k >= 3) ? 8'd1 : 8'd0);
            wait_tick(base + 1 + k);
            check("out1_m0", {7'd0, oOut1});
            if (k == 4) begin
                push(8'hFF); io_rd(16'h0041, d, s); check("cnt1_wrap", d);
            end
            if (k == 6) begin
                push(8'hFD); io_rd(16'h0041, d, s); check("cnt1_wrap2", d);
            end
        end

        // ---- counter latch on channel 0, mode 2, N = 1000 ----
        io_wr(16'h0043, 8'h34);
        io_wr(16'h0040, 8'hE8);
        io_wr(16'h0040, 8'h03);
        base = tick_cnt;
        wait_tick(base + 1 + 400);
        io_wr(16'h0043, 8'h00);
        wait_tick(base + 1 + 420);
`ifdef PIT_LATCH_EN
        push(8'h58); push(8'h02);
`else
        push(8'h44); push(8'h02);
`endif
        io_rd(16'h0040, d, s); check("latch_lsb", d);
        io_rd(16'h0040, d, s); check("latch_msb", d);
        push(8'h44); push(8'h02);
        io_rd(16'h0040, d, s); check("live_lsb", d);
        io_rd(16'h0040, d, s); check("live_msb", d);

        // ---- asynchronous reset mid-count ----
        push(8'd1); check("out1_pre_rst", {7'd0, oOut1});
        #2;
        iResetN = 1'b0;
        #1;
        push(8'd0); check("out0_arst", {7'd0, oOut0});
        push(8'd0); check("out1_arst", {7'd0, oOut1});
        push(8'd0); check("out2_arst", {7'd0, oOut2});
        iAddr = 16'h0040; iIoRd = 1'b1;
        #1;
        push(8'h00); check("rd40_in_rst", oData);
        iIoRd = 1'b0;
        @(negedge iClk);
        iResetN = 1'b1;
        @(negedge iClk);
        push(8'h00); io_rd(16'h0040, d, s); check("rd40_after_rst", d);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
